vector_dot_seq: RTL and testbench

//  Sequential 4-element single-precision dot product. It is the initiator side of the
//  fp unit go/stb protocol: drives one shared external mul and one shared external adder.
//  Use it where area matters more than latency in the Newton-Raphson datapath.

---
 rtl/vector_dot_seq.sv | 206 ++++++++++++++++++++
 tb/tb_vector_dot_seq.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_dot_seq.sv
// Sequential 4-element dot product that time-shares one external multiplier and
// one external adder through go/stb pulses; the block never interprets operand bits.
module vector_dot_seq #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a0,
  input  logic [WIDTH-1:0] i_a1,
  input  logic [WIDTH-1:0] i_a2,
  input  logic [WIDTH-1:0] i_a3,
  input  logic [WIDTH-1:0] i_b0,
  input  logic [WIDTH-1:0] i_b1,
  input  logic [WIDTH-1:0] i_b2,
  input  logic [WIDTH-1:0] i_b3,
  output logic [WIDTH-1:0] o_out,
  output logic             o_done,
  output logic             o_busy,
  output logic             o_err,
  output logic [WIDTH-1:0] o_mul_a,
  output logic [WIDTH-1:0] o_mul_b,
  output logic             o_mul_go,
  input  logic [WIDTH-1:0] i_mul_res,
  input  logic             i_mul_stb,
  output logic [WIDTH-1:0] o_add_a,
  output logic [WIDTH-1:0] o_add_b,
  output logic             o_add_sub,
  output logic             o_add_go,
  input  logic [WIDTH-1:0] i_add_res,
  input  logic             i_add_stb,
  output logic [2:0]       o_dbg_state
);

  // Handshake: a go pulse marks the operand outputs valid for exactly one cycle;
  // the unit answers with a one-cycle stb (at least one cycle later) carrying its
  // result. stb is only honoured in the matching WAIT state, otherwise dropped.

  localparam int CW = $clog2(TIMEOUT + 2);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_MUL_ISSUE = 3'd1,
    S_MUL_WAIT  = 3'd2,
    S_ADD_ISSUE = 3'd3,
    S_ADD_WAIT  = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t           r_state;
  logic [1:0]       r_idx;
  logic [WIDTH-1:0] r_a1, r_a2, r_a3;
  logic [WIDTH-1:0] r_b1, r_b2, r_b3;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_wcnt;
  logic [WIDTH-1:0] r_out;
  logic             r_done;
  logic             r_busy;
  logic             r_err;
  logic [WIDTH-1:0] r_mul_a, r_mul_b;
  logic             r_mul_go;
  logic [WIDTH-1:0] r_add_a, r_add_b;
  logic             r_add_go;

  logic [1:0]       w_nxt_idx;
  logic [WIDTH-1:0] w_nxt_a, w_nxt_b;
  logic             w_timeout;

  // Element 0 goes straight from the inputs on start, so only 1..3 are stored.
  always_comb begin
    w_nxt_idx = r_idx + 2'd1;
    w_nxt_a   = r_a3;
    w_nxt_b   = r_b3;
    case (w_nxt_idx)
      2'd1:    begin w_nxt_a = r_a1; w_nxt_b = r_b1; end
      2'd2:    begin w_nxt_a = r_a2; w_nxt_b = r_b2; end
      default: begin end
    endcase
  end

  assign w_timeout = (TIMEOUT != 0) && (r_wcnt == CW'(TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= 2'd0;
      r_a1     <= '0;
      r_a2     <= '0;
      r_a3     <= '0;
      r_b1     <= '0;
      r_b2     <= '0;
      r_b3     <= '0;
      r_acc    <= '0;
      r_wcnt   <= '0;
      r_out    <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
      r_mul_a  <= '0;
      r_mul_b  <= '0;
      r_mul_go <= 1'b0;
      r_add_a  <= '0;
      r_add_b  <= '0;
      r_add_go <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_mul_go <= 1'b0;
      r_add_go <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_a1     <= i_a1;
            r_a2     <= i_a2;
            r_a3     <= i_a3;
            r_b1     <= i_b1;
            r_b2     <= i_b2;
            r_b3     <= i_b3;
            r_idx    <= 2'd0;
            r_busy   <= 1'b1;
            r_mul_a  <= i_a0;
            r_mul_b  <= i_b0;
            r_mul_go <= 1'b1;
            r_state  <= S_MUL_ISSUE;
          end
        end
        S_MUL_ISSUE: begin
          r_wcnt  <= '0;
          r_state <= S_MUL_WAIT;
        end
        S_MUL_WAIT: begin
          if (i_mul_stb) begin
            if (r_idx == 2'd0) begin
              // First product seeds the accumulator without an add.
              r_acc    <= i_mul_res;
              r_idx    <= 2'd1;
              r_mul_a  <= w_nxt_a;
              r_mul_b  <= w_nxt_b;
              r_mul_go <= 1'b1;
              r_state  <= S_MUL_ISSUE;
            end else begin
              r_add_a  <= r_acc;
              r_add_b  <= i_mul_res;
              r_add_go <= 1'b1;
              r_state  <= S_ADD_ISSUE;
            end
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_wcnt <= r_wcnt + CW'(1);
          end
        end
        S_ADD_ISSUE: begin
          r_wcnt  <= '0;
          r_state <= S_ADD_WAIT;
        end
        S_ADD_WAIT: begin
          if (i_add_stb) begin
            r_acc <= i_add_res;
            if (r_idx == 2'd3) begin
              r_out   <= i_add_res;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_idx    <= w_nxt_idx;
              r_mul_a  <= w_nxt_a;
              r_mul_b  <= w_nxt_b;
              r_mul_go <= 1'b1;
              r_state  <= S_MUL_ISSUE;
            end
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_wcnt <= r_wcnt + CW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_out       = r_out;
  assign o_done      = r_done;
  assign o_busy      = r_busy;
  assign o_err       = r_err;
  assign o_mul_a     = r_mul_a;
  assign o_mul_b     = r_mul_b;
  assign o_mul_go    = r_mul_go;
  assign o_add_a     = r_add_a;
  assign o_add_b     = r_add_b;
  assign o_add_sub   = 1'b0;
  assign o_add_go    = r_add_go;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_vector_dot_seq.sv
// Bench for vector_dot_seq: stub FP units with programmable latency, a dot-product
// model with timing windows, and a per-cycle compare process.
module tb_vector_dot_seq;
  localparam int W  = 32;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a0 = '0, a1 = '0, a2 = '0, a3 = '0;
  logic [W-1:0] b0 = '0, b1 = '0, b2 = '0, b3 = '0;
  logic [W-1:0] o_out, o_mul_a, o_mul_b, o_add_a, o_add_b;
  logic         o_done, o_busy, o_err, o_mul_go, o_add_go, o_add_sub;
  logic [2:0]   o_dbg_state;
  logic [W-1:0] mul_res = '0, add_res = '0;
  logic         mul_stb = 1'b0, add_stb = 1'b0;

  vector_dot_seq #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_a0(a0), .i_a1(a1), .i_a2(a2), .i_a3(a3),
    .i_b0(b0), .i_b1(b1), .i_b2(b2), .i_b3(b3),
    .o_out(o_out), .o_done(o_done), .o_busy(o_busy), .o_err(o_err),
    .o_mul_a(o_mul_a), .o_mul_b(o_mul_b), .o_mul_go(o_mul_go),
    .i_mul_res(mul_res), .i_mul_stb(mul_stb),
    .o_add_a(o_add_a), .o_add_b(o_add_b), .o_add_sub(o_add_sub), .o_add_go(o_add_go),
    .i_add_res(add_res), .i_add_stb(add_stb),
    .o_dbg_state(o_dbg_state)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Check bookkeeping
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Single-precision <-> real for normal numbers and zero (all bench values are exact)
  function automatic real s2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) d = {f[31], 63'd0};
    else d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
    return r2s(s2r(x) * s2r(y));
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
    return r2s(s2r(x) + s2r(y));
  endfunction

  // Model: ((a0*b0 + a1*b1) + a2*b2) + a3*b3
  function automatic logic [31:0] dot_model(input logic [127:0] av, input logic [127:0] bv);
    logic [31:0] acc;
    acc = fmul(av[31:0], bv[31:0]);
    for (int i = 1; i < 4; i++) acc = fadd(acc, fmul(av[i*32 +: 32], bv[i*32 +: 32]));
    return acc;
  endfunction

  // Stub multiplier / adder with stray-pulse injection
  int          lm = 3, la = 2, mcnt = 0, acnt = 0;
  bit          mute_mul = 0, mute_add = 0, stray_en = 0, op_active = 0;
  logic [31:0] ma, mb, aa, ab;

  always @(negedge clk) begin
    bit m_fire, a_fire;
    m_fire = 0;
    a_fire = 0;
    mul_stb = 1'b0;
    add_stb = 1'b0;
    if (!rst_n) begin
      mcnt = 0;
      acnt = 0;
    end else begin
      if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin mul_stb = 1'b1; mul_res = fmul(ma, mb); m_fire = 1; end
      end
      if (acnt > 0) begin
        acnt--;
        if (acnt == 0) begin add_stb = 1'b1; add_res = fadd(aa, ab); a_fire = 1; end
      end
      if (o_mul_go && !mute_mul) begin mcnt = lm; ma = o_mul_a; mb = o_mul_b; end
      if (o_add_go && !mute_add) begin acnt = la; aa = o_add_a; ab = o_add_b; end
      if (stray_en) begin
        if (!m_fire && (!op_active || acnt > 0 || a_fire || o_add_go) && $urandom_range(0, 1) == 1) begin
          mul_stb = 1'b1;
          mul_res = $urandom;
        end
        if (!a_fire && (!op_active || mcnt > 0 || m_fire || o_mul_go) && $urandom_range(0, 1) == 1) begin
          add_stb = 1'b1;
          add_res = $urandom;
        end
      end
    end
  end

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_out = '0;
  logic [W-1:0] seen_out = '0;
  int exp_done_cyc = -1, exp_err_cyc = -1, busy_from = 0, busy_to = 0;
  int last_done_cyc = -1, last_err_cyc = -1, s_last = 0;
  int mul_go_n = 0, add_go_n = 0;

  task automatic chk_reset_outputs();
    chk("rst_ctl", 64'({o_done, o_busy, o_err, o_mul_go, o_add_go, o_add_sub, o_dbg_state}), 64'd0);
    chk("rst_out", 64'(o_out), 64'd0);
    chk("rst_mul_ops", {o_mul_a, o_mul_b}, 64'd0);
    chk("rst_add_ops", {o_add_a, o_add_b}, 64'd0);
  endtask

  // Compare process: every cycle, #1 after the active edge
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      chk_reset_outputs();
    end else begin
      if (cyc == exp_done_cyc && exp_q.size() > 0) last_out = exp_q.pop_front();
      chk("done", 64'(o_done), 64'(cyc == exp_done_cyc));
      chk("out", 64'(o_out), 64'(last_out));
      chk("err", 64'(o_err), 64'(cyc == exp_err_cyc));
      chk("busy", 64'(o_busy), 64'(cyc >= busy_from && cyc < busy_to));
      chk("add_sub", 64'(o_add_sub), 64'd0);
      if (o_done) begin last_done_cyc = cyc; seen_out = o_out; end
      if (o_err) last_err_cyc = cyc;
      if (o_mul_go) mul_go_n++;
      if (o_add_go) add_go_n++;
    end
  end

  // Driver: one operation; err_off = 0 means normal completion,
  // otherwise the abort is expected err_off cycles after the start cycle.
  task automatic run_op(input logic [127:0] av, input logic [127:0] bv, input int lm_i,
                        input int la_i, input bit hold, input bit stray, input int err_off);
    int s, e;
    @(negedge clk);
    lm = lm_i;
    la = la_i;
    stray_en = stray;
    {a3, a2, a1, a0} = av;
    {b3, b2, b1, b0} = bv;
    start = 1'b1;
    s = cyc;
    s_last = s;
    mul_go_n = 0;
    add_go_n = 0;
    op_active = 1;
    if (err_off == 0) begin
      e = s + 8 + 4 * lm_i + 3 * la_i;
      exp_q.push_back(dot_model(av, bv));
      exp_done_cyc = e;
    end else begin
      e = s + err_off;
      exp_err_cyc = e;
    end
    busy_from = s + 1;
    busy_to = e;
    @(negedge clk);
    {a3, a2, a1, a0} = {$urandom, $urandom, $urandom, $urandom};
    {b3, b2, b1, b0} = {$urandom, $urandom, $urandom, $urandom};
    if (!hold) start = 1'b0;
    while (cyc < e + 2) begin
      @(negedge clk);
      if (cyc >= e) start = 1'b0;
    end
    op_active = 0;
    stray_en = 0;
    if (err_off == 0) begin
      chk("mul_go_count", 64'(mul_go_n), 64'd4);
      chk("add_go_count", 64'(add_go_n), 64'd3);
    end
  endtask

  localparam logic [127:0] VA1 = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
  localparam logic [127:0] VB1 = {4{32'h3F800000}};
  localparam logic [127:0] VA2 = {32'h0, 32'h0, 32'h0, 32'h40000000};
  localparam logic [127:0] VB2 = {32'h0, 32'h0, 32'h0, 32'h40400000};
  localparam logic [127:0] VA3 = {32'h41000000, 32'h3F000000, 32'hC0000000, 32'h3FC00000};
  localparam logic [127:0] VB3 = {32'h3E800000, 32'h40800000, 32'h40400000, 32'h40000000};

  initial begin
    int s;
    repeat (3) @(negedge clk);
    // Hand-computed literals pin the model
    chk("pin_mul_2x3", 64'(fmul(32'h40000000, 32'h40400000)), 64'h40C00000);
    chk("pin_dot_10", 64'(dot_model(VA1, VB1)), 64'h41200000);
    chk("pin_dot_6", 64'(dot_model(VA2, VB2)), 64'h40C00000);
    chk("pin_dot_1", 64'(dot_model(VA3, VB3)), 64'h3F800000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op(VA1, VB1, 3, 2, 1'b0, 1'b0, 0);
    chk("latency_26", 64'(last_done_cyc - s_last), 64'd26);
    chk("out_10.0", 64'(seen_out), 64'h41200000);

    run_op(VA2, VB2, 3, 2, 1'b0, 1'b0, 0);
    chk("out_6.0", 64'(seen_out), 64'h40C00000);

    run_op(VA3, VB3, 1, 1, 1'b1, 1'b1, 0);
    chk("out_1.0_stray", 64'(seen_out), 64'h3F800000);
    run_op(VA1, VB1, 5, 4, 1'b1, 1'b1, 0);
    chk("out_10.0_stray", 64'(seen_out), 64'h41200000);

    // Multiplier never answers: abort after TO wait cycles
    mute_mul = 1;
    run_op(VA3, VB3, 3, 2, 1'b0, 1'b0, 2 + TO);
    chk("mul_timeout_cycle", 64'(last_err_cyc - s_last), 64'd10);
    chk("mul_timeout_out", 64'(o_out), 64'h41200000);
    mute_mul = 0;

    // Adder never answers with lm=1: abort in the first add wait
    mute_add = 1;
    run_op(VA2, VB2, 1, 2, 1'b0, 1'b0, 12 + 2 * 1);
    chk("add_timeout_cycle", 64'(last_err_cyc - s_last), 64'd14);
    mute_add = 0;

    // stb on exactly the TO-th wait cycle still completes
    run_op(VA3, VB3, TO, TO, 1'b0, 1'b0, 0);
    chk("edge_timeout_lat", 64'(last_done_cyc - s_last), 64'(8 + 7 * TO));
    chk("edge_timeout_out", 64'(seen_out), 64'h3F800000);

    // Reset during the first ADD_WAIT (cycles s+10..s+11 with lm=3, la=2)
    @(negedge clk);
    lm = 3;
    la = 2;
    {a3, a2, a1, a0} = VA1;
    {b3, b2, b1, b0} = VB1;
    start = 1'b1;
    s = cyc;
    op_active = 1;
    exp_q.push_back(dot_model(VA1, VB1));
    exp_done_cyc = s + 26;
    busy_from = s + 1;
    busy_to = s + 26;
    @(negedge clk);
    start = 1'b0;
    while (cyc < s + 10) @(negedge clk);
    exp_done_cyc = -1;
    busy_to = 0;
    exp_q.delete();
    last_out = '0;
    op_active = 0;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_op(VA3, VB3, 2, 3, 1'b0, 1'b0, 0);
    chk("post_reset_out", 64'(seen_out), 64'h3F800000);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
